// File: rtl/alu_result_tx_if.sv
// Request/response and serial-line bundle between the ALU datapath and the result transmitter.
// The master drives the request; the slave (alu_result_tx) drives the status and the UART line.
interface alu_result_tx_if #(
    parameter int unsigned N = 16
);
    logic         start;
    logic [N-1:0] result;
    logic [4:0]   flags;
    logic         ready;
    logic         done;
    logic         tx;

    modport master (
        output start,
        output result,
        output flags,
        input  ready,
        input  done,
        input  tx
    );

    modport slave (
        input  start,
        input  result,
        input  flags,
        output ready,
        output done,
        output tx
    );
endinterface

// File: rtl/alu_result_tx.sv
// Sends {flags} and a 16-bit ALU result as three back-to-back 8N1 UART bytes:
// {3'b000, flags}, result[15:8], result[7:0].
module alu_result_tx #(
    parameter int unsigned N            = 16,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input logic            clk,
    input logic            rst,
    alu_result_tx_if.slave bus
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] baud_q;
    logic [2:0]      bit_q;
    logic [1:0]      byte_q;
    logic [N+4:0]    hold_q;
    logic            tx_q;
    logic            done_q;

    logic [7:0] cur_byte;
    logic       baud_end;
    logic [2:0] bit_nxt;

    assign baud_end = (baud_q == BaudLast);
    assign bit_nxt  = bit_q + 3'd1;

    // Frame layout assumes N == 16: byte1/byte2 are the two halves of the result.
    always_comb begin
        cur_byte = hold_q[7:0];
        case (byte_q)
            2'd0:    cur_byte = {3'b000, hold_q[N+4:N]};
            2'd1:    cur_byte = hold_q[15:8];
            default: cur_byte = hold_q[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            hold_q  <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (bus.start) begin
                        hold_q  <= {bus.flags, bus.result};
                        baud_q  <= '0;
                        bit_q   <= '0;
                        byte_q  <= '0;
                        tx_q    <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= cur_byte[0];
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_q <= bit_nxt;
                            tx_q  <= cur_byte[bit_nxt];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StStop: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        bit_q  <= '0;
                        if (byte_q == 2'd2) begin
                            byte_q  <= '0;
                            tx_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            // Next start bit follows the stop bit with no idle gap.
                            byte_q  <= byte_q + 2'd1;
                            tx_q    <= 1'b0;
                            state_q <= StStart;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.ready = (state_q == StIdle);
    assign bus.done  = done_q;
    assign bus.tx    = tx_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx: checks every tx cycle of each frame against a bit-level model
// built from hand-computed byte values, plus reset, busy-start and back-to-back sequences.
module tb_alu_result_tx;

    localparam int CPB = 4;

    typedef struct {
        logic [15:0] res;
        logic [4:0]  fl;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    alu_result_tx_if #(.N(16)) bus ();

    alu_result_tx #(
        .N           (16),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Expected line level at offset n after the start bit begins.
    function automatic logic exp_bit(input logic [7:0] e0, input logic [7:0] e1,
                                     input logic [7:0] e2, input int n);
        int         bp;
        int         k;
        int         j;
        logic [7:0] b;
        bp = n / CPB;
        k  = bp / 10;
        j  = bp % 10;
        b  = (k == 0) ? e0 : ((k == 1) ? e1 : e2);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // Called in cycle A+1; returns in cycle A+121 after checking the done cycle.
    task automatic run_window(input string name, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [15:0] nres,
                              input logic [4:0] nfl, input bit hold, input int busy_n);
        int         first_bad;
        bit         rdy_bad;
        logic [7:0] dec [3];
        logic       e;
        first_bad = -1;
        rdy_bad   = 1'b0;
        for (int n = 0; n < 30 * CPB; n++) begin
            int bp;
            int j;
            e = exp_bit(e0, e1, e2, n);
            if (bus.tx !== e && first_bad < 0) first_bad = n;
            if (bus.ready !== 1'b0 || bus.done !== 1'b0) rdy_bad = 1'b1;
            bp = n / CPB;
            j  = bp % 10;
            if ((n % CPB) == CPB / 2 && j >= 1 && j <= 8) dec[bp/10][j-1] = bus.tx;
            if (n == 0) begin
                bus.start  = hold;
                bus.result = nres;
                bus.flags  = nfl;
            end
            if (busy_n >= 0 && n == busy_n) begin
                bus.start  = 1'b1;
                bus.result = 16'hAAAA;
                bus.flags  = 5'h1F;
            end
            if (busy_n >= 0 && n == busy_n + 1) bus.start = 1'b0;
            step();
        end
        check({name, " waveform first bad offset"}, first_bad, -1);
        check({name, " ready/done during frame"}, 32'(rdy_bad), 32'd0);
        check({name, " byte0"}, 32'(dec[0]), 32'(e0));
        check({name, " byte1"}, 32'(dec[1]), 32'(e1));
        check({name, " byte2"}, 32'(dec[2]), 32'(e2));
        check({name, " done/ready at end"}, {30'd0, bus.done, bus.ready}, 32'd3);
    endtask

    task automatic post_idle(input string name);
        step();
        check({name, " after done tx/ready/done"}, {29'd0, bus.tx, bus.ready, bus.done},
              32'b110);
    endtask

    task automatic idle_watch(input string name, input int cycles);
        bit err;
        err = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.tx !== 1'b1 || bus.ready !== 1'b1 || bus.done !== 1'b0) err = 1'b1;
            step();
        end
        check({name, " idle line quiet"}, 32'(err), 32'd0);
    endtask

    task automatic accept(input logic [15:0] res, input logic [4:0] fl);
        bus.start  = 1'b1;
        bus.result = res;
        bus.flags  = fl;
        step();
    endtask

    vec_t vecs [4];

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{res: 16'h1234, fl: 5'b00011, b0: 8'h03, b1: 8'h12, b2: 8'h34};
        vecs[1] = '{res: 16'h0000, fl: 5'b00000, b0: 8'h00, b1: 8'h00, b2: 8'h00};
        vecs[2] = '{res: 16'hA5C3, fl: 5'b01010, b0: 8'h0A, b1: 8'hA5, b2: 8'hC3};
        vecs[3] = '{res: 16'h8001, fl: 5'b10000, b0: 8'h10, b1: 8'h80, b2: 8'h01};

        // Reset held for 3 cycles with start asserted.
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.result = 16'h1234;
        bus.flags  = 5'h03;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset tx/ready/done", {29'd0, bus.tx, bus.ready, bus.done}, 32'b110);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        step();
        check("post-reset no accept", {29'd0, bus.tx, bus.ready, bus.done}, 32'b110);
        idle_watch("post-reset", 8);

        foreach (vecs[i]) begin
            accept(vecs[i].res, vecs[i].fl);
            run_window($sformatf("vec%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].b2,
                       vecs[i].res, vecs[i].fl, 1'b0, -1);
            post_idle($sformatf("vec%0d", i));
        end

        // Inputs cleared right after capture must not alter the frame.
        accept(16'hFFFF, 5'b11111);
        run_window("capture", 8'h1F, 8'hFF, 8'hFF, 16'h0000, 5'b00000, 1'b0, -1);
        post_idle("capture");

        // Start pulse during byte1 data bits is ignored and not queued.
        accept(16'h8001, 5'b00000);
        run_window("busy", 8'h00, 8'h80, 8'h01, 16'h8001, 5'b00000, 1'b0, 50);
        post_idle("busy");
        idle_watch("busy no second frame", 200);

        // start held high: second frame accepted in the done cycle.
        accept(16'h00FF, 5'b00000);
        run_window("b2b first", 8'h00, 8'h00, 8'hFF, 16'hFF00, 5'b00000, 1'b1, -1);
        step();
        run_window("b2b second", 8'h00, 8'hFF, 8'h00, 16'hFF00, 5'b00000, 1'b0, -1);
        post_idle("b2b");

        // Reset during byte1 data bits abandons the frame.
        accept(16'h1234, 5'b00011);
        bus.start = 1'b0;
        repeat (50) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid-frame reset tx/ready/done", {29'd0, bus.tx, bus.ready, bus.done}, 32'b110);
        idle_watch("aborted frame", 150);
        accept(16'h5A5A, 5'b10100);
        run_window("after reset", 8'h14, 8'h5A, 8'h5A, 16'h5A5A, 5'b10100, 1'b0, -1);
        post_idle("after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
